// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard detection for the pipeline. It sits beside the ID stage and
//   compares the ID source registers against the EX and MEM destinations.
//   On a hazard it holds the PC and the IF/ID register and inserts an
//   ID/EX bubble. It also tracks a multi-cycle MUL/DIV unit and keeps a
//   saturating count of stalled cycles.
//
// Ports
//   clock, reset     rising-edge clock; asynchronous active-low reset
//   id_valid         ID holds a real instruction
//   id_use_stage     0 = sources used in ID (branch/jump), 1 = used in EX
//   id_rs, id_rt     ID source registers
//   id_is_mdu        ID instruction is MUL/DIV
//   id_reads_hilo    ID instruction is MFHI/MFLO
//   flush            ID instruction is squashed this cycle
//   ex_reg_write     ID/EX instruction writes a register
//   ex_is_load       ID/EX instruction is a load
//   ex_dest          ID/EX destination
//   mem_is_load      EX/MEM instruction is a load
//   mem_dest         EX/MEM destination
//   pc_stall         hold PC
//   if_id_stall      hold IF/ID
//   id_ex_bubble     zero ID/EX control
//   stall_cause      00 none, 01 ID-use, 10 load-use, 11 MDU busy
//   mdu_busy         MDU occupancy counter is nonzero
//   stall_count      saturating count of stalled cycles
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int DEST_W      = 6,
  parameter int LOAD_LAT    = 1,
  parameter int MDU_LAT     = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_use_stage,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_is_mdu,
  input  logic                   id_reads_hilo,
  input  logic                   flush,
  input  logic                   ex_reg_write,
  input  logic                   ex_is_load,
  input  logic [DEST_W-1:0]      ex_dest,
  input  logic                   mem_is_load,
  input  logic [DEST_W-1:0]      mem_dest,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_bubble,
  output logic [1:0]             stall_cause,
  output logic                   mdu_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [STALL_CNT_W-1:0] stall_count_reg;

  logic m_ex, m_mem;
  logic hz_id, hz_ld, hz_mdu;
  logic stall, issue;

  // A source matches a destination only when the destination is not $0;
  // sources are zero-extended so destinations in the upper encoding never
  // alias an architectural register.
  function automatic logic src_match(input logic [REG_AW-1:0] src,
                                     input logic [DEST_W-1:0] dest);
    return (DEST_W'(src) == dest) && (dest != '0);
  endfunction

  always_comb begin
    m_ex   = src_match(id_rs, ex_dest)  || src_match(id_rt, ex_dest);
    m_mem  = src_match(id_rs, mem_dest) || src_match(id_rt, mem_dest);

    hz_id  = id_valid && !id_use_stage &&
             ((ex_reg_write && m_ex) || (mem_is_load && m_mem));
    hz_ld  = id_valid && id_use_stage &&
             ((ex_is_load && m_ex) || ((LOAD_LAT == 2) && mem_is_load && m_mem));
    hz_mdu = id_valid && (id_is_mdu || id_reads_hilo) && (cnt_reg != '0);

    // Qualifying with reset keeps every output low while reset is held,
    // whatever the inputs are doing.
    stall  = reset && !flush && (hz_mdu || hz_ld || hz_id);
    issue  = reset && id_valid && id_is_mdu && !stall && !flush;
  end

  always_comb begin
    stall_cause = 2'b00;
    if (stall) begin
      if (hz_mdu)     stall_cause = 2'b11;
      else if (hz_ld) stall_cause = 2'b10;
      else            stall_cause = 2'b01;
    end
  end

  assign pc_stall     = stall;
  assign if_id_stall  = stall;
  assign id_ex_bubble = stall;
  assign mdu_busy     = (cnt_reg != '0);
  assign stall_count  = stall_count_reg;

  // MDU occupancy FSM. Once issued an op always runs to completion; flush
  // only affects whether a new op is issued.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(MDU_LAT);
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Stall performance counter, saturating at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (stall && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit. Two instances share one set of inputs:
// u0 uses LOAD_LAT=1 and a 16-bit counter, u1 uses LOAD_LAT=2 and a 4-bit
// counter. Stimulus pushes hand-computed expectations into a queue; a
// monitor pops them on the falling edge and compares.
module tb_hazard_ctrl_unit;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic       id_use_stage;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_is_mdu;
  logic       id_reads_hilo;
  logic       flush;
  logic       ex_reg_write;
  logic       ex_is_load;
  logic [5:0] ex_dest;
  logic       mem_is_load;
  logic [5:0] mem_dest;

  logic        pc_stall0, if_id_stall0, id_ex_bubble0, mdu_busy0;
  logic [1:0]  stall_cause0;
  logic [15:0] stall_count0;
  logic        pc_stall1, if_id_stall1, id_ex_bubble1, mdu_busy1;
  logic [1:0]  stall_cause1;
  logic [3:0]  stall_count1;

  hazard_ctrl_unit #(
    .REG_AW(5), .DEST_W(6), .LOAD_LAT(1), .MDU_LAT(8), .STALL_CNT_W(16)
  ) u0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_use_stage(id_use_stage),
    .id_rs(id_rs), .id_rt(id_rt), .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
    .flush(flush), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .mem_is_load(mem_is_load), .mem_dest(mem_dest),
    .pc_stall(pc_stall0), .if_id_stall(if_id_stall0), .id_ex_bubble(id_ex_bubble0),
    .stall_cause(stall_cause0), .mdu_busy(mdu_busy0), .stall_count(stall_count0)
  );

  hazard_ctrl_unit #(
    .REG_AW(5), .DEST_W(6), .LOAD_LAT(2), .MDU_LAT(8), .STALL_CNT_W(4)
  ) u1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_use_stage(id_use_stage),
    .id_rs(id_rs), .id_rt(id_rt), .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
    .flush(flush), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .mem_is_load(mem_is_load), .mem_dest(mem_dest),
    .pc_stall(pc_stall1), .if_id_stall(if_id_stall1), .id_ex_bubble(id_ex_bubble1),
    .stall_cause(stall_cause1), .mdu_busy(mdu_busy1), .stall_count(stall_count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        s0;
    logic [1:0]  c0;
    logic [15:0] n0;
    logic        s1;
    logic [1:0]  c1;
    logic [3:0]  n1;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected counter values, advanced from the hand-written stall flags.
  logic [15:0] exp_n0 = '0;
  logic [3:0]  exp_n1 = '0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: on each falling edge compare the pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn %-12s u0: stall=%0b cause=%0d cnt=%0d | u1: stall=%0b cause=%0d cnt=%0d | busy=%0b/%0b",
                 e.name, pc_stall0, stall_cause0, stall_count0,
                 pc_stall1, stall_cause1, stall_count1, mdu_busy0, mdu_busy1);
        chk({e.name, " u0.pc_stall"},     16'(pc_stall0),     16'(e.s0));
        chk({e.name, " u0.if_id_stall"},  16'(if_id_stall0),  16'(e.s0));
        chk({e.name, " u0.id_ex_bubble"}, 16'(id_ex_bubble0), 16'(e.s0));
        chk({e.name, " u0.stall_cause"},  16'(stall_cause0),  16'(e.c0));
        chk({e.name, " u0.mdu_busy"},     16'(mdu_busy0),     16'(e.busy));
        chk({e.name, " u0.stall_count"},  stall_count0,       e.n0);
        chk({e.name, " u1.pc_stall"},     16'(pc_stall1),     16'(e.s1));
        chk({e.name, " u1.if_id_stall"},  16'(if_id_stall1),  16'(e.s1));
        chk({e.name, " u1.id_ex_bubble"}, 16'(id_ex_bubble1), 16'(e.s1));
        chk({e.name, " u1.stall_cause"},  16'(stall_cause1),  16'(e.c1));
        chk({e.name, " u1.mdu_busy"},     16'(mdu_busy1),     16'(e.busy));
        chk({e.name, " u1.stall_count"},  16'(stall_count1),  16'(e.n1));
      end
    end
  end

  task automatic clr();
    id_valid      = 1'b0;
    id_use_stage  = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    id_is_mdu     = 1'b0;
    id_reads_hilo = 1'b0;
    flush         = 1'b0;
    ex_reg_write  = 1'b0;
    ex_is_load    = 1'b0;
    ex_dest       = '0;
    mem_is_load   = 1'b0;
    mem_dest      = '0;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input string nm, input logic s0, input logic [1:0] c0,
                      input logic s1, input logic [1:0] c1, input logic busy);
    exp_t e;
    if (!reset) begin
      exp_n0 = '0;
      exp_n1 = '0;
    end
    e.name = nm;
    e.s0 = s0; e.c0 = c0; e.n0 = exp_n0;
    e.s1 = s1; e.c1 = c1; e.n1 = exp_n1;
    e.busy = busy;
    sb_q.push_back(e);
    if (s0) exp_n0 = exp_n0 + 16'd1;
    if (s1 && (exp_n1 != 4'hF)) exp_n1 = exp_n1 + 4'd1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clr();
    @(posedge clock);
    #1;

    // Reset holds all outputs low even with a live hazard on the inputs.
    id_valid = 1'b1; id_rs = 5'd5; ex_reg_write = 1'b1; ex_dest = 6'd5;
    step("reset_hold", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // ID-use hazards.
    step("id_use_ex", 1, 1, 1, 1, 0);
    clr(); id_valid = 1'b1; id_rt = 5'd5; mem_is_load = 1'b1; mem_dest = 6'd5;
    step("id_use_mem", 1, 1, 1, 1, 0);
    clr(); id_valid = 1'b1; ex_reg_write = 1'b1;
    step("zero_reg", 0, 0, 0, 0, 0);
    clr(); id_valid = 1'b1; id_rs = 5'd5; ex_reg_write = 1'b1; ex_dest = 6'h25;
    step("upper_dest", 0, 0, 0, 0, 0);
    clr(); id_rs = 5'd5; ex_reg_write = 1'b1; ex_dest = 6'd5;
    step("not_valid", 0, 0, 0, 0, 0);

    // Load-use hazards.
    clr(); id_valid = 1'b1; id_use_stage = 1'b1; id_rt = 5'd9; ex_is_load = 1'b1; ex_dest = 6'd9;
    step("load_use_ex", 1, 2, 1, 2, 0);
    clr(); id_valid = 1'b1; id_use_stage = 1'b1; id_rt = 5'd9; mem_is_load = 1'b1; mem_dest = 6'd9;
    step("load_use_mem", 0, 0, 1, 2, 0);
    clr(); id_valid = 1'b1; id_use_stage = 1'b1; id_rt = 5'd9; ex_reg_write = 1'b1; ex_dest = 6'd9;
    step("alu_fwd", 0, 0, 0, 0, 0);
    clr(); id_valid = 1'b1; id_use_stage = 1'b1; id_rt = 5'd9; mem_dest = 6'd9;
    step("mem_noload", 0, 0, 0, 0, 0);
    clr(); id_valid = 1'b1; id_use_stage = 1'b1; id_rt = 5'd9; ex_is_load = 1'b1; ex_dest = 6'd9;
    flush = 1'b1;
    step("flush_ld", 0, 0, 0, 0, 0);

    // MDU issue followed by MFHI, with priority and flush cases inside.
    clr(); id_valid = 1'b1; id_is_mdu = 1'b1;
    step("mul_issue", 0, 0, 0, 0, 0);
    clr(); id_valid = 1'b1; id_reads_hilo = 1'b1;
    step("mfhi_wait1", 1, 3, 1, 3, 1);
    step("mfhi_wait2", 1, 3, 1, 3, 1);
    id_use_stage = 1'b1; id_rt = 5'd9; ex_is_load = 1'b1; ex_dest = 6'd9;
    step("mdu_prio", 1, 3, 1, 3, 1);
    clr(); id_valid = 1'b1; id_reads_hilo = 1'b1; flush = 1'b1;
    step("mdu_flush", 0, 0, 0, 0, 1);
    flush = 1'b0;
    for (int k = 5; k <= 8; k++) step("mfhi_wait", 1, 3, 1, 3, 1);
    step("mfhi_go", 0, 0, 0, 0, 0);

    // Reset in the middle of an MDU op (counter at 4).
    clr(); id_valid = 1'b1; id_is_mdu = 1'b1;
    step("mul_issue2", 0, 0, 0, 0, 0);
    clr(); id_valid = 1'b1; id_reads_hilo = 1'b1;
    for (int k = 1; k <= 4; k++) step("mfhi_wait", 1, 3, 1, 3, 1);
    reset = 1'b0;
    step("reset_mdu", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("mfhi_after", 0, 0, 0, 0, 0);

    // Counter saturation on the 4-bit instance.
    clr(); id_valid = 1'b1; id_rs = 5'd5; ex_reg_write = 1'b1; ex_dest = 6'd5;
    for (int k = 0; k < 20; k++) step("cnt_run", 1, 1, 1, 1, 0);
    clr();
    step("cnt_hold", 0, 0, 0, 0, 0);
    step("cnt_hold2", 0, 0, 0, 0, 0);

    @(negedge clock);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
